// File: rtl/input_stream_writer_pkg.sv
// Shared helpers for the input stream writer: lane geometry, lane masks and ring-pointer wrap.
package input_stream_pkg;

  localparam int MAX_LANES = 256;

  function automatic int samples_per_word(input int word_w, input int sample_w);
    return word_w / sample_w;
  endfunction

  // Lane-granular mask with lanes 0..n-1 set.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic int next_row(input int ptr, input int rows);
    return (ptr >= rows - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/input_stream_writer_if.sv
// Narrow valid/ready sample stream from the chip input interface into the writer.
interface input_stream_writer_if #(
  parameter int SAMPLE_BIT_WIDTH = 4
);
  logic                        sample_valid;
  logic                        sample_ready;
  logic [SAMPLE_BIT_WIDTH-1:0] sample_data;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/input_stream_writer_occupancy.sv
// Ring occupancy tracker: commits increment, releases decrement, underflow sets a sticky error.
module ring_occupancy_counter #(
  parameter  int INPUT_ROWS = 32,
  localparam int CW         = $clog2(INPUT_ROWS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          release_error
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      release_error <= 1'b0;
    end else if (clear) begin
      count         <= '0;
      release_error <= 1'b0;
    end else begin
      // A simultaneous commit and release cancel out, even at zero.
      unique case ({inc, dec})
        2'b10: count <= count + 1'b1;
        2'b01: begin
          if (count == '0) release_error <= 1'b1;
          else             count         <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign full = (count == CW'(INPUT_ROWS));

endmodule

// File: rtl/input_stream_writer.sv
// Packs stream samples into rows and writes them into the ring-buffered input memory.
// Optional build macro INPUT_WRITER_IMMEDIATE_WRITE_EN writes each sample as it arrives.
module input_stream_writer
  import input_stream_pkg::*;
#(
  parameter  int INPUT_WORD_BIT_WIDTH = 64,
  parameter  int INPUT_ROWS           = 32,
  parameter  int SAMPLE_BIT_WIDTH     = 4,
  localparam int INPUT_ADDRESS_WIDTH  = $clog2(INPUT_ROWS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            clear,
  input_stream_writer_if.slave            stream,
  input  logic                            flush,
  input  logic                            rows_release,
  output logic                            input_control_write_enable,
  output logic [INPUT_ADDRESS_WIDTH-1:0]  input_control_address_write,
  output logic [INPUT_WORD_BIT_WIDTH-1:0] input_control_data_in,
  output logic [INPUT_WORD_BIT_WIDTH-1:0] input_control_mask,
  output logic [INPUT_ADDRESS_WIDTH:0]    rows_available,
  output logic                            row_committed,
  output logic                            release_error
);

  localparam int SAMPLES_PER_WORD = samples_per_word(INPUT_WORD_BIT_WIDTH, SAMPLE_BIT_WIDTH);
  localparam int LW = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

  logic [LW-1:0]                   lane_idx_p0;
  logic [INPUT_ADDRESS_WIDTH-1:0]  wr_ptr_p0;
  logic                            full;
  logic                            accept;
  logic                            row_done;
  logic                            partial;
  logic                            commit;
  logic [LW:0]                     fill_cnt;
  logic [INPUT_WORD_BIT_WIDTH-1:0] lane_field;

  logic                            vld_p1;
  logic                            committed_p1;
  logic [INPUT_ADDRESS_WIDTH-1:0]  addr_p1;
  logic [INPUT_WORD_BIT_WIDTH-1:0] data_p1;
  logic [INPUT_WORD_BIT_WIDTH-1:0] mask_p1;

  function automatic logic [INPUT_WORD_BIT_WIDTH-1:0] expand_lanes(input logic [MAX_LANES-1:0] lanes);
    logic [INPUT_WORD_BIT_WIDTH-1:0] bits;
    bits = '0;
    for (int i = 0; i < SAMPLES_PER_WORD; i++)
      bits[i*SAMPLE_BIT_WIDTH +: SAMPLE_BIT_WIDTH] = {SAMPLE_BIT_WIDTH{lanes[i]}};
    return bits;
  endfunction

  assign stream.sample_ready = enable & ~clear & ~full;
  assign accept     = stream.sample_valid & stream.sample_ready;
  assign row_done   = accept & (lane_idx_p0 == LW'(SAMPLES_PER_WORD - 1));
  // Lanes filled once this cycle's sample (if any) lands.
  assign fill_cnt   = {1'b0, lane_idx_p0} + {{LW{1'b0}}, accept};
  assign partial    = flush & ~row_done & (fill_cnt != '0);
  assign commit     = (row_done | partial) & ~clear;
  assign lane_field = INPUT_WORD_BIT_WIDTH'(stream.sample_data) << (lane_idx_p0 * SAMPLE_BIT_WIDTH);

  // Stage p0: lane index and ring write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx_p0 <= '0;
      wr_ptr_p0   <= '0;
    end else if (clear) begin
      lane_idx_p0 <= '0;
      wr_ptr_p0   <= '0;
    end else if (commit) begin
      lane_idx_p0 <= '0;
      wr_ptr_p0   <= INPUT_ADDRESS_WIDTH'(next_row(int'(wr_ptr_p0), INPUT_ROWS));
    end else if (accept) begin
      lane_idx_p0 <= lane_idx_p0 + 1'b1;
    end
  end

`ifdef INPUT_WRITER_IMMEDIATE_WRITE_EN
  // Stage p1: every accepted sample is written straight into its lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      committed_p1 <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      mask_p1      <= '0;
    end else begin
      vld_p1       <= accept;
      committed_p1 <= commit;
      if (accept) begin
        addr_p1 <= wr_ptr_p0;
        data_p1 <= lane_field;
        mask_p1 <= expand_lanes(lane_mask(int'(lane_idx_p0) + 1) ^ lane_mask(int'(lane_idx_p0)));
      end
    end
  end
`else
  logic [INPUT_WORD_BIT_WIDTH-1:0] word_p0;
  logic [INPUT_WORD_BIT_WIDTH-1:0] merged;

  assign merged = accept ? (word_p0 | lane_field) : word_p0;

  // Stage p0: packing register, zeroed per row so unfilled lanes read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                word_p0 <= '0;
    else if (clear || commit)  word_p0 <= '0;
    else if (accept)           word_p0 <= merged;
  end

  // Stage p1: registered row write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      committed_p1 <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      mask_p1      <= '0;
    end else begin
      vld_p1       <= commit;
      committed_p1 <= commit;
      if (commit) begin
        addr_p1 <= wr_ptr_p0;
        data_p1 <= merged;
        mask_p1 <= expand_lanes(lane_mask(int'(fill_cnt)));
      end
    end
  end
`endif

  ring_occupancy_counter #(
    .INPUT_ROWS (INPUT_ROWS)
  ) u_occupancy (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .inc           (commit),
    .dec           (rows_release),
    .count         (rows_available),
    .full          (full),
    .release_error (release_error)
  );

  assign input_control_write_enable  = vld_p1;
  assign input_control_address_write = addr_p1;
  assign input_control_data_in       = data_p1;
  assign input_control_mask          = mask_p1;
  assign row_committed               = committed_p1;

endmodule

// File: tb/tb_input_stream_writer.sv
// Bench for input_stream_writer (default packed-row build) against a queue-based ring model.
module tb_input_stream_writer;

  localparam int W    = 64;
  localparam int ROWS = 32;
  localparam int SW   = 4;
  localparam int SPW  = W / SW;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          flush = 1'b0;
  logic          rows_release = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [W-1:0]  din;
  logic [W-1:0]  mask;
  logic [AW:0]   rows_available;
  logic          row_committed;
  logic          release_error;

  input_stream_writer_if #(.SAMPLE_BIT_WIDTH(SW)) sif ();

  input_stream_writer #(
    .INPUT_WORD_BIT_WIDTH (W),
    .INPUT_ROWS           (ROWS),
    .SAMPLE_BIT_WIDTH     (SW)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .enable                      (enable),
    .clear                       (clear),
    .stream                      (sif),
    .flush                       (flush),
    .rows_release                (rows_release),
    .input_control_write_enable  (we),
    .input_control_address_write (addr),
    .input_control_data_in       (din),
    .input_control_mask          (mask),
    .rows_available              (rows_available),
    .row_committed               (row_committed),
    .release_error               (release_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [W-1:0]  m;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  rc_cnt = 0;
  int  rdy_bad = 0;

  logic [SW-1:0] m_row[$];
  int            m_ptr;
  int            m_occ;
  bit            m_err;

  always @(negedge clk) begin
    if (rst_n) begin
      if (we) got_q.push_back({addr, din, mask});
      if (row_committed) rc_cnt++;
    end
  end

  task automatic model_reset();
    m_row.delete();
    m_ptr = 0;
    m_occ = 0;
    m_err = 1'b0;
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    rc_cnt  = 0;
    rdy_bad = 0;
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input bit v, input logic [SW-1:0] d, input bit f, input bit rel, input bit en);
    bit rdy, acc, com;
    logic [W-1:0] wd, wm;
    sif.sample_valid = v;
    sif.sample_data  = d;
    flush            = f;
    rows_release     = rel;
    enable           = en;
    rdy = en && !clear && (m_occ < ROWS);
    #1;
    if (sif.sample_ready !== rdy) rdy_bad++;
    acc = v && rdy;
    if (clear) begin
      model_reset();
    end else begin
      if (acc) m_row.push_back(d);
      com = (m_row.size() == SPW) || (f && m_row.size() > 0);
      if (com) begin
        wd = '0;
        wm = '0;
        foreach (m_row[i]) begin
          wd |= W'(m_row[i]) << (SW * i);
          wm |= W'(4'hF) << (SW * i);
        end
        exp_q.push_back({AW'(m_ptr), wd, wm});
        m_ptr = (m_ptr + 1) % ROWS;
        m_row.delete();
      end
      if (com && !rel) m_occ++;
      else if (rel && !com) begin
        if (m_occ == 0) m_err = 1'b1;
        else            m_occ--;
      end
    end
    @(posedge clk);
    #1;
    sif.sample_valid = 1'b0;
    flush            = 1'b0;
    rows_release     = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(0, '0, 0, 0, 1);
    clear = 1'b0;
    step(0, '0, 0, 0, 1);
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({we, addr, din, mask, rows_available, row_committed, release_error} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got we=%b addr=%0d data=%h mask=%h avail=%0d rc=%b err=%b want all 0",
               we, addr, din, mask, rows_available, row_committed, release_error);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_logs();
    enable = 1'b1;
    #1;
    n_cmp++;
    if (sif.sample_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", sif.sample_ready);
    end
  endtask

  task automatic test_full_row();
    wr_t want;
    clear_logs();
    for (int i = 0; i < SPW; i++) step(1, 4'(i + 1), 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    want = {5'd0, 64'h0FED_CBA9_8765_4321, {W{1'b1}}};
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      n_bad++;
      $display("FAIL full_row got %0d writes first=%h want 1 write %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, want);
    end
    n_cmp++;
    if (rows_available !== 6'd1 || rc_cnt != 1) begin
      n_bad++;
      $display("FAIL full_row_avail got avail=%0d rc=%0d want 1/1", rows_available, rc_cnt);
    end
    n_cmp++;
    if (we !== 1'b0 || din !== 64'h0FED_CBA9_8765_4321) begin
      n_bad++;
      $display("FAIL full_row_hold got we=%b data=%h want 0 and held row", we, din);
    end
  endtask

  task automatic test_flush();
    wr_t want;
    clear_logs();
    step(1, 4'hA, 0, 0, 1);
    step(1, 4'hB, 0, 0, 1);
    step(1, 4'hC, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    want = {5'd1, 64'h0000_0000_0000_0CBA, 64'h0000_0000_0000_0FFF};
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      n_bad++;
      $display("FAIL flush_partial got %0d writes first=%h want 1 write %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, want);
    end
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (got_q.size() != 1 || rows_available !== 6'd2) begin
      n_bad++;
      $display("FAIL flush_idle got %0d writes avail=%0d want 1 write avail 2", got_q.size(), rows_available);
    end
  endtask

  task automatic test_fill_wrap();
    do_clear();
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < SPW; i++) step(1, 4'($urandom), 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 4'($urandom), 0, 0, 1);
    n_cmp++;
    if (sif.sample_ready !== 1'b0 || rows_available !== 6'd32) begin
      n_bad++;
      $display("FAIL fill_full got ready=%b avail=%0d want 0/32", sif.sample_ready, rows_available);
    end
    n_cmp++;
    if (got_q.size() != ROWS) begin
      n_bad++;
      $display("FAIL fill_count got %0d writes want %0d", got_q.size(), ROWS);
    end else begin
      foreach (got_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i] || got_q[i].a !== AW'(i)) begin
          n_bad++;
          $display("FAIL fill_row%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    step(0, '0, 0, 1, 1);
    n_cmp++;
    if (sif.sample_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_release_ready got %b want 1", sif.sample_ready);
    end
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < SPW; i++) step(1, 4'($urandom), 0, 0, 1);
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].a !== 5'd0) begin
      n_bad++;
      $display("FAIL wrap_row got %0d writes first=%h want addr 0 row %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, (exp_q.size() > 0) ? exp_q[0] : '0);
    end
    n_cmp++;
    if (rdy_bad != 0) begin
      n_bad++;
      $display("FAIL fill_ready_trace got %0d wrong ready cycles want 0", rdy_bad);
    end
  endtask

  task automatic test_simul_release();
    do_clear();
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < SPW; i++) step(1, 4'($urandom), 0, 0, 1);
    for (int i = 0; i < SPW - 1; i++) step(1, 4'($urandom), 0, 0, 1);
    step(1, 4'($urandom), 0, 1, 1);
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (rows_available !== 6'd5 || got_q.size() != 6) begin
      n_bad++;
      $display("FAIL commit_release got avail=%0d writes=%0d want 5/6", rows_available, got_q.size());
    end
    for (int i = 0; i < 5; i++) step(0, '0, 0, 1, 1);
    n_cmp++;
    if (release_error !== 1'b0) begin
      n_bad++;
      $display("FAIL release_no_err got %b want 0", release_error);
    end
    step(0, '0, 0, 1, 1);
    n_cmp++;
    if (release_error !== 1'b1 || rows_available !== 6'd0) begin
      n_bad++;
      $display("FAIL underflow got err=%b avail=%0d want 1/0", release_error, rows_available);
    end
    do_clear();
    n_cmp++;
    if (release_error !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_err got %b want 0", release_error);
    end
  endtask

  task automatic test_random();
    bit v, f, rel, en;
    do_clear();
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      f   = ($urandom_range(0, 19) == 0);
      rel = ($urandom_range(0, 9) < 2);
      en  = ($urandom_range(0, 9) != 0);
      step(v, 4'($urandom), f, rel, en);
    end
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_count got %0d writes want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (got_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rand_row%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (rows_available !== (AW + 1)'(m_occ) || release_error !== m_err) begin
      n_bad++;
      $display("FAIL rand_state got avail=%0d err=%b want %0d/%b", rows_available, release_error, m_occ, m_err);
    end
    n_cmp++;
    if (rdy_bad != 0 || rc_cnt != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_ready_rc got badready=%0d rc=%0d want 0/%0d", rdy_bad, rc_cnt, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 7; i++) step(1, 4'($urandom), 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({we, addr, din, mask, rows_available, row_committed, release_error} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got we=%b addr=%0d data=%h mask=%h avail=%0d want all 0",
               we, addr, din, mask, rows_available);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_logs();
    for (int i = 0; i < SPW; i++) step(1, 4'($urandom), 0, 0, 1);
    step(0, '0, 0, 0, 1);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].a !== 5'd0 || got_q[0].m !== {W{1'b1}}) begin
      n_bad++;
      $display("FAIL post_reset_row got %0d writes first=%h want %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sample_valid = 1'b0;
    sif.sample_data  = '0;
    model_reset();
    test_reset();
    test_full_row();
    test_flush();
    test_fill_wrap();
    test_simul_release();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_stream_writer.md
Name: input_stream_writer

Overview:
Producer-side writer for the managed input memory's control write port. Accepts a narrow valid/ready sample stream from the chip's input interface and packs samples into INPUT_WORD_BIT_WIDTH-wide rows. Writes the rows into the input memory, which is used as a ring buffer. Tracks row occupancy against consumer releases and exerts backpressure when the ring is full.

Parameters:
INPUT_WORD_BIT_WIDTH, 64, width of one input memory row
INPUT_ROWS, 32, rows in input memory; any value >= 2, power of two not required
SAMPLE_BIT_WIDTH, 4, bits per stream sample; must divide INPUT_WORD_BIT_WIDTH
SAMPLES_PER_WORD (localparam), INPUT_WORD_BIT_WIDTH/SAMPLE_BIT_WIDTH
INPUT_ADDRESS_WIDTH (localparam), $clog2(INPUT_ROWS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  stream acceptance allowed
clear  in  1  synchronous soft reset of pointers, occupancy and packing state
sample_valid  in  1  producer has a sample
sample_ready  out  1  block accepts a sample this cycle
sample_data  in  SAMPLE_BIT_WIDTH  sample value
flush  in  1  commit the partially filled row
rows_release  in  1  consumer has finished the oldest committed row
input_control_write_enable  out  1  memory write strobe
input_control_address_write  out  INPUT_ADDRESS_WIDTH  row address being written
input_control_data_in  out  INPUT_WORD_BIT_WIDTH  write data
input_control_mask  out  INPUT_WORD_BIT_WIDTH  per-bit write mask, 1 = write
rows_available  out  INPUT_ADDRESS_WIDTH+1  committed, unreleased rows
row_committed  out  1  one-cycle pulse when a row is committed
release_error  out  1  sticky flag, set by a release while occupancy is 0

Behaviour:
- Reset (rst_n low, asynchronous): all registers and outputs are 0, including write strobe, address, data, mask, lane index, write pointer, occupancy and release_error.
- sample_ready = enable & ~clear & (occupancy < INPUT_ROWS). Combinational. Does not depend on sample_valid.
- A sample is accepted when sample_valid & sample_ready. It goes to lane k = lane_idx, occupying bits [k*SAMPLE_BIT_WIDTH +: SAMPLE_BIT_WIDTH]. Lane 0 is the LSB.
- Accepting the last lane (SAMPLES_PER_WORD-1) completes the row. Registered write on the next cycle:
  - write_enable=1 for exactly one cycle, address=wr_ptr, data=packed word, mask all ones.
  - row_committed pulses in the same cycle.
  - wr_ptr advances, wrapping from INPUT_ROWS-1 to 0.
  - occupancy increments.
  - lane_idx returns to 0.
- Back-to-back full rows are supported with no bubble.
- flush with lane_idx>0 (counting a sample accepted in the same cycle):
  - Commits the partial row on the next cycle.
  - Mask covers lanes 0..n-1 only. Unfilled data bits are 0.
  - lane_idx returns to 0.
- flush with lane_idx==0 is ignored. This includes the case where a sample accepted in the same cycle completes the row: the normal commit happens and there is no extra write.
- rows_release decrements occupancy.
  - Commit and release in the same cycle leave occupancy unchanged.
  - Release while occupancy==0 (and no commit) is ignored and sets release_error. Only rst_n or clear clears the flag.
- When occupancy reaches INPUT_ROWS, ready drops the following cycle. Any partially packed lanes and the in-flight commit are preserved.
- enable low: ready low. Packing state is held. A flush is still honoured.
- clear: zeroes lane_idx, wr_ptr, occupancy and release_error. Drops any in-flight write. Priority: clear > commit/release.
- write_enable is 0 in every cycle without a commit. Address, data and mask hold their last values.

Optional Feature:
INPUT_WRITER_IMMEDIATE_WRITE_EN:
- Defined:
  - Each accepted sample is written on the next cycle to wr_ptr. The mask covers only that sample's lane and the data carries the sample in that lane.
  - The commit on the last lane, or on a flush, updates the pointer and occupancy but issues no extra write.
  - Flush causes no write.
- Undefined: the packed-word behaviour described above.

Decomposition:
- Package input_stream_pkg holds lane_mask(n) and row-wrap helper functions plus the SAMPLES_PER_WORD derivation.
- Sub-module ring_occupancy_counter handles occupancy, full detection, simultaneous inc/dec, and underflow flag generation.

Test Plan:
- Defaults; 16 samples 0x1..0xF,0x0 with valid held high -> one write, addr 0, data 0x0FEDCBA987654321, mask all ones; rows_available=1.
- 3 samples 0xA,0xB,0xC then flush -> write data 0x0000000000000CBA, mask 0x0000000000000FFF; flush when idle -> no write.
- Stream 32 full rows with no release -> ready low after the 32nd commit, addresses 0..31; one release -> ready high; next row written to address 0 (wrap).
- Commit and release in the same cycle at occupancy 5 -> stays 5; release at occupancy 0 -> release_error=1, occupancy 0.
- rst_n asserted mid-row after 7 samples -> all outputs 0 immediately; next row starts at lane 0, addr 0.
- With INPUT_WRITER_IMMEDIATE_WRITE_EN: sample 0x7 at lane 2 -> write data 0x700, mask 0xF00; 16th sample commits with no extra write.
